// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA configuration frame loader: sync word, header
// field positions, FSM state encoding and width helpers.
package efpga_cfg_pkg;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

    localparam int unsigned END_BIT = 31;
    localparam int unsigned COL_MSB = 15;
    localparam int unsigned COL_LSB = 8;
    localparam int unsigned IDX_MSB = 7;
    localparam int unsigned IDX_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) width++;
        return width;
    endfunction

    // Counter width that never collapses to zero bits
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/efpga_frame_loader_if.sv
// Config word stream in, assembled frame and status out. The loader takes the
// slave modport; the upstream word source takes the master modport.
interface efpga_frame_loader_if #(
    parameter int unsigned FRAME_WORDS = 4
);
    logic [31:0]               write_data_i;
    logic                      write_strobe_i;
    logic [32*FRAME_WORDS-1:0] frame_data_o;
    logic [7:0]                frame_column_o;
    logic [7:0]                frame_index_o;
    logic                      frame_strobe_o;
    logic                      config_active_o;
    logic                      config_done_o;
    logic                      error_o;

    modport master (
        output write_data_i, write_strobe_i,
        input  frame_data_o, frame_column_o, frame_index_o, frame_strobe_o,
        input  config_active_o, config_done_o, error_o
    );

    modport slave (
        input  write_data_i, write_strobe_i,
        output frame_data_o, frame_column_o, frame_index_o, frame_strobe_o,
        output config_active_o, config_done_o, error_o
    );
endinterface

// File: rtl/frame_word_buffer.sv
// FRAME_WORDS x 32 register file: one indexed write port, whole contents read flat.
module frame_word_buffer #(
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          write_en,
    input  logic [IDX_W-1:0]              write_idx,
    input  logic [31:0]                   write_word,
    output logic [FRAME_WORDS-1:0][31:0]  read_words
);
    logic [FRAME_WORDS-1:0][31:0] mem_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q <= '0;
        end else if (write_en) begin
            mem_q[write_idx] <= write_word;
        end
    end

    assign read_words = mem_q;
endmodule

// File: rtl/efpga_frame_loader.sv
// Parses the config word stream (sync, headers, data) into fabric frames.
// Optional idle abort in HEADER/DATA is built when FRAME_LOADER_TIMEOUT_EN is defined.
module efpga_frame_loader
    import efpga_cfg_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int unsigned FRAME_WORDS    = 4,
    parameter int unsigned NUM_COLUMNS    = 16,
    parameter int unsigned FRAMES_PER_COL = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input logic                  clk_i,
    input logic                  reset_i,
    efpga_frame_loader_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_WORDS - 1);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         skip_q, skip_d;
    logic [7:0]                   col_q, col_d, idx_q, idx_d;
    logic [FRAME_WORDS-1:0][31:0] frame_q, frame_d, buf_words, frame_next;
    logic [7:0]                   fcol_q, fcol_d, fidx_q, fidx_d;
    logic                         fstb_q, fstb_d;
    logic                         active_q, active_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;
    logic                         buf_we;
    logic [7:0]                   hdr_col, hdr_idx;
    logic                         hdr_bad;

    assign hdr_col = bus.write_data_i[COL_MSB:COL_LSB];
    assign hdr_idx = bus.write_data_i[IDX_MSB:IDX_LSB];
    assign hdr_bad = (32'(hdr_col) >= NUM_COLUMNS) || (32'(hdr_idx) >= FRAMES_PER_COL);

    frame_word_buffer #(
        .FRAME_WORDS (FRAME_WORDS),
        .IDX_W       (CNT_W)
    ) u_buffer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .write_en   (buf_we),
        .write_idx  (cnt_q),
        .write_word (bus.write_data_i),
        .read_words (buf_words)
    );

    // Last word lands in the buffer on the same edge, so splice it in directly
    always_comb begin
        frame_next                = buf_words;
        frame_next[FRAME_WORDS-1] = bus.write_data_i;
    end

`ifdef FRAME_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;
    assign tmo_hit = (state_q != IDLE) && !bus.write_strobe_i
                  && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        skip_d   = skip_q;
        col_d    = col_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        fcol_d   = fcol_q;
        fidx_d   = fidx_q;
        fstb_d   = 1'b0;
        active_d = active_q;
        done_d   = 1'b0;
        error_d  = error_q;
        buf_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.write_strobe_i && bus.write_data_i == SYNC_WORD) begin
                    state_d  = HEADER;
                    active_d = 1'b1;
                    error_d  = 1'b0;
                end
            end
            HEADER: begin
                // Sync has bit 31 set, so it must be filtered before the end flag
                if (bus.write_strobe_i && bus.write_data_i != SYNC_WORD) begin
                    if (bus.write_data_i[END_BIT]) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        col_d   = hdr_col;
                        idx_d   = hdr_idx;
                        cnt_d   = '0;
                        skip_d  = hdr_bad;
                        error_d = error_q | hdr_bad;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.write_strobe_i) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SLOT) begin
                        state_d = HEADER;
                        if (!skip_q) begin
                            fstb_d  = 1'b1;
                            frame_d = frame_next;
                            fcol_d  = col_q;
                            fidx_d  = idx_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FRAME_LOADER_TIMEOUT_EN
        tmo_d = (bus.write_strobe_i || state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);
        if (tmo_hit) begin
            state_d  = IDLE;
            active_d = 1'b0;
            error_d  = 1'b1;
            tmo_d    = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            skip_q   <= 1'b0;
            col_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            fcol_q   <= '0;
            fidx_q   <= '0;
            fstb_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            skip_q   <= skip_d;
            col_q    <= col_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            fcol_q   <= fcol_d;
            fidx_q   <= fidx_d;
            fstb_q   <= fstb_d;
            active_q <= active_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

`ifdef FRAME_LOADER_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`endif

    assign bus.frame_data_o    = frame_q;
    assign bus.frame_column_o  = fcol_q;
    assign bus.frame_index_o   = fidx_q;
    assign bus.frame_strobe_o  = fstb_q;
    assign bus.config_active_o = active_q;
    assign bus.config_done_o   = done_q;
    assign bus.error_o         = error_q;
endmodule

// File: tb/tb_efpga_frame_loader.sv
// Directed bench for efpga_frame_loader; the timeout scenario is added when
// FRAME_LOADER_TIMEOUT_EN is defined (TIMEOUT_CYCLES overridden to 100).
module tb_efpga_frame_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    int   n_done = 0;
    int   last_cyc = 0;
    int   prev_cyc = 0;

    efpga_frame_loader_if #(.FRAME_WORDS(4)) bus ();

    efpga_frame_loader #(
        .SYNC_WORD      (32'hFAB0_FAB1),
        .FRAME_WORDS    (4),
        .NUM_COLUMNS    (16),
        .FRAMES_PER_COL (20),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Count frame and done pulses, remembering when frames went out
    always @(negedge clk) begin
        if (bus.frame_strobe_o === 1'b1) begin
            n_strobe = n_strobe + 1;
            prev_cyc = last_cyc;
            last_cyc = cyc;
        end
        if (bus.config_done_o === 1'b1) n_done = n_done + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        tick();
        bus.write_data_i   = w;
        bus.write_strobe_i = 1'b1;
    endtask

    task automatic idle();
        tick();
        bus.write_strobe_i = 1'b0;
    endtask

    initial begin
        bus.write_data_i   = 32'h0;
        bus.write_strobe_i = 1'b0;
        repeat (3) tick();
        chk("rst_strobe", 128'(bus.frame_strobe_o), 128'd0);
        chk("rst_data",   bus.frame_data_o, 128'd0);
        chk("rst_active", 128'(bus.config_active_o), 128'd0);
        chk("rst_error",  128'(bus.error_o), 128'd0);
        rst = 1'b0;

        // Basic frame
        send(32'hFAB0_FAB1); send(32'h0000_0305);
        send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333); send(32'h4444_4444);
        idle();
        chk("f1_strobe", 128'(bus.frame_strobe_o), 128'd1);
        chk("f1_col",    128'(bus.frame_column_o), 128'd3);
        chk("f1_idx",    128'(bus.frame_index_o), 128'd5);
        chk("f1_data",   bus.frame_data_o, 128'h44444444_33333333_22222222_11111111);
        chk("f1_active", 128'(bus.config_active_o), 128'd1);
        tick();
        chk("f1_pulse",  128'(bus.frame_strobe_o), 128'd0);
        chk("f1_hold",   bus.frame_data_o, 128'h44444444_33333333_22222222_11111111);
        send(32'h8000_0000); idle();
        chk("end1_done",   128'(bus.config_done_o), 128'd1);
        chk("end1_active", 128'(bus.config_active_o), 128'd0);
        tick();
        chk("end1_pulse",  128'(bus.config_done_o), 128'd0);

        // Pre-sync garbage is dropped; boundary column 10 / index 19 accepted
        send(32'hDEAD_BEEF); send(32'h1234_5678); idle(); tick();
        chk("pre_active", 128'(bus.config_active_o), 128'd0);
        chk("pre_count",  128'(n_strobe), 128'd1);
        send(32'hFAB0_FAB1); send(32'h0000_0A13);
        send(32'hA0A0_A0A0); send(32'hA1A1_A1A1); send(32'hA2A2_A2A2); send(32'hA3A3_A3A3);
        idle();
        chk("f2_strobe", 128'(bus.frame_strobe_o), 128'd1);
        chk("f2_col",    128'(bus.frame_column_o), 128'd10);
        chk("f2_idx",    128'(bus.frame_index_o), 128'd19);
        chk("f2_count",  128'(n_strobe), 128'd2);

        // Column 18 out of range: error, frame skipped, outputs hold
        send(32'h0000_1205); send(32'h5555_5555);
        chk("bad_err", 128'(bus.error_o), 128'd1);
        send(32'h6666_6666); send(32'h7777_7777); send(32'h8888_8888); idle();
        chk("bad_strobe", 128'(bus.frame_strobe_o), 128'd0);
        chk("bad_count",  128'(n_strobe), 128'd2);
        chk("bad_hold",   128'(bus.frame_column_o), 128'd10);
        send(32'h0000_0F00);
        send(32'hC0C0_C0C0); send(32'hC1C1_C1C1); send(32'hC2C2_C2C2); send(32'hC3C3_C3C3);
        idle();
        chk("f3_strobe", 128'(bus.frame_strobe_o), 128'd1);
        chk("f3_col",    128'(bus.frame_column_o), 128'd15);
        chk("f3_idx",    128'(bus.frame_index_o), 128'd0);
        chk("f3_err",    128'(bus.error_o), 128'd1);
        // Index 20 out of range
        send(32'h0000_0014);
        send(32'h1); send(32'h2); send(32'h3); send(32'h4); idle(); tick();
        chk("badidx_count", 128'(n_strobe), 128'd3);

        // End, re-sync clears error, repeated sync ignored, back-to-back frames
        send(32'h8000_0000); idle();
        chk("end2_done", 128'(n_done), 128'd2);
        send(32'hFAB0_FAB1); idle();
        chk("sync_clr_err", 128'(bus.error_o), 128'd0);
        chk("sync_active",  128'(bus.config_active_o), 128'd1);
        send(32'hFAB0_FAB1); send(32'h0000_0102);
        send(32'hB0B0_B0B0); send(32'hB1B1_B1B1); send(32'hB2B2_B2B2); send(32'hB3B3_B3B3);
        send(32'h0000_0203);
        send(32'hD0D0_D0D0); send(32'hD1D1_D1D1); send(32'hD2D2_D2D2); send(32'hD3D3_D3D3);
        send(32'h8000_0000); idle();
        chk("b2b_count",  128'(n_strobe), 128'd5);
        chk("b2b_gap",    128'(last_cyc - prev_cyc), 128'd5);
        chk("b2b_col",    128'(bus.frame_column_o), 128'd2);
        chk("b2b_idx",    128'(bus.frame_index_o), 128'd3);
        chk("b2b_data",   bus.frame_data_o, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        chk("end3_done",  128'(bus.config_done_o), 128'd1);
        chk("end3_active", 128'(bus.config_active_o), 128'd0);

        // Reset mid-frame discards the partial frame
        send(32'hFAB0_FAB1); send(32'h0000_0102); send(32'hEEEE_0000); send(32'hEEEE_0001);
        idle();
        rst = 1'b1;
        #1;
        chk("mrst_active", 128'(bus.config_active_o), 128'd0);
        chk("mrst_data",   bus.frame_data_o, 128'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("mrst_count", 128'(n_strobe), 128'd5);
        send(32'hFAB0_FAB1); send(32'h0000_0704);
        send(32'hE0E0_E0E0); send(32'hE1E1_E1E1); send(32'hE2E2_E2E2); send(32'hE3E3_E3E3);
        idle();
        chk("f6_strobe", 128'(bus.frame_strobe_o), 128'd1);
        chk("f6_col",    128'(bus.frame_column_o), 128'd7);
        chk("f6_idx",    128'(bus.frame_index_o), 128'd4);
        chk("f6_data",   bus.frame_data_o, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0);
        chk("f6_count",  128'(n_strobe), 128'd6);

`ifdef FRAME_LOADER_TIMEOUT_EN
        // Stall after one data word: abort exactly 100 cycles later
        send(32'h0000_0001); send(32'h9999_9999); idle();
        repeat (99) tick();
        chk("tmo_before", 128'(bus.config_active_o), 128'd1);
        tick();
        chk("tmo_active", 128'(bus.config_active_o), 128'd0);
        chk("tmo_err",    128'(bus.error_o), 128'd1);
        send(32'h0000_0305); idle(); tick();
        chk("tmo_ignore", 128'(bus.config_active_o), 128'd0);
        chk("tmo_count",  128'(n_strobe), 128'd6);
        chk("tmo_done",   128'(n_done), 128'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/efpga_frame_loader.md
Name: efpga_frame_loader

Overview:
- Consumes the 32-bit configuration word stream (write data + single-cycle write strobe) that the USB config path produces.
- Detects the bitstream sync word, parses per-frame header words, and assembles FRAME_WORDS data words into one frame.
- Emits each frame to the eFPGA configuration fabric as a wide frame-data bus, column/frame address and a one-cycle frame strobe.
- Sits directly downstream of the USB-CDC config word assembler, upstream of the fabric's frame registers.

Parameters:
- SYNC_WORD, 32'hFAB0_FAB1, stream start marker
- FRAME_WORDS, 4, 32-bit data words per frame (fabric rows)
- NUM_COLUMNS, 16, valid column range 0..NUM_COLUMNS-1
- FRAMES_PER_COL, 20, valid frame index range 0..FRAMES_PER_COL-1
- TIMEOUT_CYCLES, 1200000, idle cycles before a mid-frame abort (used only with the optional feature)

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- write_data_i  in  32  configuration word
- write_strobe_i  in  1  one-cycle qualifier for write_data_i; may be asserted every cycle
- frame_data_o  out  32*FRAME_WORDS  assembled frame; word 0 in bits [31:0]
- frame_column_o  out  8  column of the emitted frame
- frame_index_o  out  8  frame index within the column
- frame_strobe_o  out  1  one-cycle pulse; frame_* outputs valid
- config_active_o  out  1  high from sync until end/abort
- config_done_o  out  1  one-cycle pulse on a clean end-of-stream
- error_o  out  1  sticky; cleared by the next sync word

Behaviour:
- Interface decision: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset: all outputs 0; state IDLE; word counter 0; frame buffer 0.
- IDLE: a strobed word equal to SYNC_WORD moves to HEADER, sets config_active_o and clears error_o. Any other strobed word is dropped.
- HEADER: strobed word decoded as follows:
  - [31] end flag: if 1, pulse config_done_o next cycle, clear config_active_o, go to IDLE.
  - [15:8] column, [7:0] frame index; latch both, clear counter, go to DATA.
  - A word equal to SYNC_WORD in HEADER is ignored (re-sync tolerance).
  - Column >= NUM_COLUMNS or index >= FRAMES_PER_COL: set error_o, still go to DATA with a skip flag.
- DATA:
  - Every strobed word is written to buffer slot [counter] and counter increments. There is no sync detection in DATA.
  - On the strobe of word FRAME_WORDS-1, the next cycle has frame_strobe_o=1 (unless skip), frame_data_o holding all words, and column/index outputs valid. The state returns to HEADER in that same edge.
  - Latency from the last data strobe to frame_strobe_o is 1 cycle.
- Throughput: no busy state. Strobes on consecutive cycles are always accepted, including a header immediately after the last data word.
- frame_data_o/column/index hold their values until the next emitted frame.
- Counter width is clog2(FRAME_WORDS), minimum 1. Counter wraps to 0 only via the HEADER transition.
- Reset mid-frame: the partial frame is discarded, no strobe is emitted, and the block returns to IDLE.

Optional Feature:
- Macro: FRAME_LOADER_TIMEOUT_EN.
- Defined:
  - A counter clears on every strobe and counts while in HEADER or DATA.
  - When it reaches TIMEOUT_CYCLES, set error_o, drop config_active_o and go to IDLE without any strobe. No config_done_o.
- Undefined: no counter. The block waits indefinitely in HEADER/DATA.

Decomposition:
- Shared package efpga_cfg_pkg:
  - SYNC_WORD default, header bit positions (END_BIT=31, COL_MSB/LSB=15/8, IDX_MSB/LSB=7/0)
  - state encoding (IDLE, HEADER, DATA)
  - `clog2` helper
- Sub-module frame_word_buffer: FRAME_WORDS x 32 register file with indexed write and flat read. The FSM stays in the top module.

Test Plan:
- Sync 0xFAB0_FAB1, header 0x0000_0305, data 0x11111111..0x44444444 on consecutive cycles -> one frame_strobe_o a cycle after the 4th word; column=3, index=5; frame_data_o = 0x44444444_33333333_22222222_11111111.
- Words 0xDEADBEEF, 0x12345678 before sync, then a valid frame -> the pre-sync words are ignored and exactly one strobe is emitted.
- Header 0x0000_1205 (column 18 >= 16) plus 4 data words, then a valid frame -> error_o=1 and no strobe for the first frame. The second frame strobes and error_o stays set.
- Two full frames with no idle cycles, then header 0x8000_0000 -> two strobes 5 cycles apart; config_done_o pulses one cycle after the end word; config_active_o=0.
- Reset_i asserted after 2 of 4 data words, then a clean sync and frame -> no strobe for the partial frame; the new frame is correct.
- With FRAME_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall after 1 data word -> at cycle 100 error_o=1, config_active_o=0, state IDLE; a subsequent non-sync word is ignored.
